// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// input, and the decoded head-of-queue output towards control_unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_ready;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [2:0]            funct3;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [6:0]            funct7;
  logic                  protocol_error;

  // The fetch unit itself
  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    input  instr_ready,
    output instr_valid, instr, instr_pc,
    output opcode, rd, funct3, rs1, rs2, funct7,
    output protocol_error
  );

  // Memory, branch unit and downstream decode seen from outside
  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    output instr_ready,
    input  instr_valid, instr, instr_pc,
    input  opcode, rd, funct3, rs1, rs2, funct7,
    input  protocol_error
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, keeps at most one variable-latency
// fetch in flight, buffers returned words in a 2-entry queue and presents
// the head entry already split into its instruction fields.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    addr_t       pc;
    logic [31:0] word;
  } entry_t;

  // Architectural state
  addr_t      r_fetch_pc;
  addr_t      r_imem_addr;      // doubles as the PC of the in-flight fetch
  logic       r_imem_req;
  logic       r_outstanding;
  logic       r_discard;        // in-flight fetch belongs to a squashed path
  logic       r_protocol_error;
  entry_t     r_queue [2];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  // Combinational next-state
  logic       w_valid;
  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_stray;
  logic       w_outstanding_n;
  logic       w_discard_n;
  logic [1:0] w_count_n;
  addr_t      w_fetch_pc_n;
  addr_t      w_redirect_target;
  entry_t     w_head;

  assign w_redirect_target = bus.redirect_pc & ~addr_t'(3);
  assign w_valid           = (r_count != 2'd0);
  assign w_pop             = w_valid && bus.instr_ready;
  // A redirect squashes whatever arrives in the same cycle.
  assign w_push            = bus.imem_rvalid && r_outstanding && !r_discard
                             && !bus.redirect_valid;
  assign w_stray           = bus.imem_rvalid && !r_outstanding;

  // Post-update bookkeeping; issue is decided from these updated values so a
  // freed slot or a redirect target is fetched on the very next cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
    w_fetch_pc_n    = r_fetch_pc;
    w_outstanding_n = r_outstanding;
    w_discard_n     = r_discard;
    w_count_n       = r_count;
    if (bus.redirect_valid) begin
      w_fetch_pc_n    = w_redirect_target;
      // A fetch still in flight must be thrown away when it finally returns.
      w_outstanding_n = r_outstanding && !bus.imem_rvalid;
      w_discard_n     = r_outstanding && !bus.imem_rvalid;
      w_count_n       = 2'd0;
    end else begin
      if (bus.imem_rvalid && r_outstanding) begin
        w_outstanding_n = 1'b0;
        w_discard_n     = 1'b0;
      end
      w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
    w_issue = !w_outstanding_n && !w_discard_n && (w_count_n != 2'd2);
  end

  // Control state: PC, request pulse, in-flight tracking, queue pointers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_fetch_pc       <= RESET_PC;
      r_imem_addr      <= RESET_PC;
      r_imem_req       <= 1'b0;
      r_outstanding    <= 1'b0;
      r_discard        <= 1'b0;
      r_protocol_error <= 1'b0;
      r_head           <= 1'b0;
      r_tail           <= 1'b0;
      r_count          <= 2'd0;
    end else begin
      r_imem_req    <= w_issue;
      r_discard     <= w_discard_n;
      r_count       <= w_count_n;
      r_outstanding <= w_outstanding_n || w_issue;
      if (w_issue) begin
        r_imem_addr <= w_fetch_pc_n;
        r_fetch_pc  <= w_fetch_pc_n + addr_t'(4);
      end else begin
        r_fetch_pc  <= w_fetch_pc_n;
      end
      if (bus.redirect_valid) begin
        r_head <= 1'b0;
        r_tail <= 1'b0;
      end else begin
        if (w_push) r_tail <= ~r_tail;
        if (w_pop)  r_head <= ~r_head;
      end
      if (w_stray) r_protocol_error <= 1'b1;
    end
  end

  // Queue payload storage, written on push
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; r_count gates every read so stale contents are never visible.
    if (w_push) begin
      r_queue[r_tail] <= '{pc: r_imem_addr, word: bus.imem_rdata};
    end
  end

  assign w_head = r_queue[r_head];

  assign bus.imem_req       = r_imem_req;
  assign bus.imem_addr      = r_imem_addr;
  assign bus.protocol_error = r_protocol_error;
  assign bus.instr_valid    = w_valid;
  assign bus.instr          = w_valid ? w_head.word : 32'd0;
  assign bus.instr_pc       = w_valid ? w_head.pc   : addr_t'(0);
  assign bus.opcode         = bus.instr[6:0];
  assign bus.rd             = bus.instr[11:7];
  assign bus.funct3         = bus.instr[14:12];
  assign bus.rs1            = bus.instr[19:15];
  assign bus.rs2            = bus.instr[24:20];
  assign bus.funct7         = bus.instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a variable-latency memory model, a
// program-order scoreboard (PC sequence restarting at each redirect target),
// directed scenarios and a randomized phase.
module tb_instr_fetch_unit;
  localparam int AW = 32;

  typedef struct { int c; logic [AW-1:0] a; } req_t;
  typedef struct { logic [AW-1:0] pc; logic [31:0] w; } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int delivered = 0;
  int mem_lat_min = 1;
  int mem_lat_max = 1;
  bit mem_inject = 1'b0;
  req_t req_log[$];
  ent_t exp_q[$];
  logic [AW-1:0] model_pc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Memory contents: any address maps to a distinct word; address 8 holds a known R-type.
  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    if (a == 32'h8) return 32'h40B5_0533;
    return {a[7:0] ^ 8'h5A, a[31:24], a[15:8] ^ 8'hC3, a[23:16]} ^ 32'h0013_0013;
  endfunction

  function automatic logic [AW-1:0] req_a(input int i);
    return (i < req_log.size()) ? req_log[i].a : 'x;
  endfunction

  function automatic int req_c(input int i);
    return (i < req_log.size()) ? req_log[i].c : -1000;
  endfunction

  // Expected stream: consecutive PCs from the current program-order point.
  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: model_pc, w: word_of(model_pc)});
      model_pc += 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [AW-1:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    exp_q.delete();
    model_pc = tgt & ~32'h3;
    refill();
  endtask

  task automatic do_reset(input bit ready, input int lmin, input int lmax);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = ready;
    mem_lat_min = lmin;
    mem_lat_max = lmax;
    exp_q.delete();
    model_pc = '0;
    req_log.delete();
    ticks(2);
    mid();
    check("reset_imem", {bus.imem_req, bus.imem_addr}, '0);
    check("reset_head", {bus.instr_valid, bus.instr, bus.instr_pc,
                         bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode}, '0);
    check("reset_protocol_error", bus.protocol_error, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(input int n, input string name);
    int budget = 60;
    while (req_log.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (req_log.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s: timed out, got %0d requests, want %0d", name, req_log.size(), n);
    end
  endtask

  task automatic wait_head(input logic [AW-1:0] pc, input string name);
    int budget = 60;
    while (!(bus.instr_valid && bus.instr_pc == pc) && budget > 0) begin
      tick();
      budget--;
    end
    if (!(bus.instr_valid && bus.instr_pc == pc)) begin
      checks++;
      failures++;
      $display("FAIL %s: timed out, head pc %0h valid %0d, want pc %0h", name,
               bus.instr_pc, bus.instr_valid, pc);
    end
  endtask

  // Memory model: one response per request after a random latency.
  initial begin : memory
    bit pend;
    int cnt;
    logic [AW-1:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(paddr);
            pend = 1'b0;
          end
        end
        if (mem_inject) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = 32'hDEAD_BEEF;
          mem_inject = 1'b0;
        end
        if (bus.imem_req) begin
          check("single_outstanding", pend, 1'b0);
          req_log.push_back('{c: cyc, a: bus.imem_addr});
          pend  = 1'b1;
          cnt   = $urandom_range(mem_lat_max, mem_lat_min);
          paddr = bus.imem_addr;
        end
      end
    end
  end

  // Monitor: compares each accepted head entry against the expected stream.
  initial begin : monitor
    bit hold_v;
    logic [AW-1:0] hold_pc;
    logic [31:0] hold_w;
    ent_t e;
    hold_v = 1'b0;
    hold_pc = '0;
    hold_w = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", bus.instr_valid, 1'b1);
          check("hold_head", {bus.instr_pc, bus.instr}, {hold_pc, hold_w});
        end
        hold_v = 1'b0;
        if (!bus.instr_valid) begin
          check("empty_outputs", {bus.instr, bus.instr_pc, bus.funct7, bus.rs2,
                                  bus.rs1, bus.funct3, bus.rd, bus.opcode}, '0);
        end else if (!bus.redirect_valid) begin
          if (bus.instr_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_underflow: pc %0h delivered with nothing expected", bus.instr_pc);
            end else begin
              e = exp_q.pop_front();
              check("sb_pc", bus.instr_pc, e.pc);
              check("sb_instr", bus.instr, e.w);
              check("sb_fields", {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode},
                    {e.w[31:25], e.w[24:20], e.w[19:15], e.w[14:12], e.w[11:7], e.w[6:0]});
              delivered++;
            end
          end else begin
            hold_v  = 1'b1;
            hold_pc = bus.instr_pc;
            hold_w  = bus.instr;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    int n;
    int d0;
    logic [AW-1:0] tgt;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    // Streaming with L=1: requests to 0,4,8 on alternate cycles; decode of pc 8.
    do_reset(1'b1, 1, 1);
    wait_head(32'h8, "t1_head_pc8");
    check("t1_word8", bus.instr, 32'h40B5_0533);
    check("t1_decode", {bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2},
          {7'h33, 3'd0, 7'h20, 5'd10, 5'd10, 5'd11});
    ticks(6);
    check("t1_addrs", {req_a(0), req_a(1), req_a(2)}, {32'h0, 32'h4, 32'h8});
    check("t1_gap01", req_c(1) - req_c(0), 2);
    check("t1_gap12", req_c(2) - req_c(1), 2);

    // Back-pressure: queue fills after two fetches; stray rvalid is flagged and dropped.
    do_reset(1'b0, 1, 1);
    ticks(10);
    check("t2_req_count", req_log.size(), 2);
    check("t2_addrs", {req_a(0), req_a(1)}, {32'h0, 32'h4});
    check("t2_head", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 32'h0, word_of(32'h0)});
    mem_inject = 1'b1;
    ticks(2);
    check("t2_perr_set", bus.protocol_error, 1'b1);
    check("t2_req_count_after_stray", req_log.size(), 2);
    bus.instr_ready = 1'b1;
    ticks(12);
    check("t2_resume_addr", req_a(2), 32'h8);
    check("t2_perr_sticky", bus.protocol_error, 1'b1);

    // Redirect while the fetch to 8 is in flight (L=4): stale response dropped.
    do_reset(1'b0, 4, 4);
    wait_head(32'h0, "t3_first_entry");
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    wait_req(3, "t3_req8");
    check("t3_req8_addr", req_a(2), 32'h8);
    k = req_c(2);
    tick();
    do_redirect(32'h0000_0102);
    mid();
    check("t3_valid_before_flush", bus.instr_valid, 1'b1);
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    check("t3_flushed", bus.instr_valid, 1'b0);
    tick();
    mid();
    check("t3_stale_rvalid_cycle", bus.imem_rvalid, 1'b1);
    tick();
    mid();
    check("t3_stale_dropped", bus.instr_valid, 1'b0);
    wait_req(4, "t3_req_target");
    check("t3_target_addr", req_a(3), 32'h0000_0100);
    check("t3_target_cycle", req_c(3) - k, 5);
    bus.instr_ready = 1'b1;
    ticks(12);

    // Redirect coincident with rvalid and a pop at count=1: no push, no discard wait.
    do_reset(1'b0, 1, 1);
    wait_req(2, "t4_req4");
    do_redirect(32'h0000_0203);
    bus.instr_ready = 1'b1;
    mid();
    check("t4_setup", {bus.imem_rvalid, bus.instr_valid}, 2'b11);
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    check("t4_no_push", bus.instr_valid, 1'b0);
    wait_req(3, "t4_req_target");
    check("t4_target_addr", req_a(2), 32'h0000_0200);
    check("t4_target_cycle", req_c(2) - req_c(1), 2);
    ticks(10);

    // Redirect to the top of the address space: fetch wraps to 0.
    do_reset(1'b0, 1, 1);
    wait_req(2, "t5_fill");
    ticks(3);
    n = req_log.size();
    do_redirect(32'hFFFF_FFFC);
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    check("t5_flushed", bus.instr_valid, 1'b0);
    ticks(12);
    check("t5_wrap_addrs", {req_a(n), req_a(n + 1), req_a(n + 2)},
          {32'hFFFF_FFFC, 32'h0, 32'h4});

    // Randomized traffic: latency 1..5, random back-pressure and redirects.
    do_reset(1'b1, 1, 5);
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
        do_redirect(tgt);
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    ticks(20);
    check("random_progress", (delivered - d0) > 100, 1'b1);
    check("random_no_protocol_error", bus.protocol_error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of control_unit. Holds the PC and issues word fetches to instruction memory, which answers with variable latency. Fetched words are buffered in a 2-entry queue. The head entry is split into opcode/funct3/funct7/rd/rs1/rs2 for control_unit and the register file. Branch/jump resolution redirects the PC and flushes all in-flight work.

Parameters:
ADDR_WIDTH, 32, width of PC, imem_addr, redirect_pc and instr_pc
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  one-cycle fetch request pulse, registered
imem_addr  out  ADDR_WIDTH  fetch address, valid when imem_req=1
imem_rvalid  in  1  fetch response strobe
imem_rdata  in  32  fetched instruction, valid with imem_rvalid
redirect_valid  in  1  taken branch/jump; replace PC and flush
redirect_pc  in  ADDR_WIDTH  redirect target
instr_ready  in  1  downstream accepts head entry
instr_valid  out  1  head entry present
instr  out  32  head instruction word
instr_pc  out  ADDR_WIDTH  PC of head instruction
opcode  out  7  instr[6:0]
rd  out  5  instr[11:7]
funct3  out  3  instr[14:12]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
funct7  out  7  instr[31:25]
protocol_error  out  1  sticky flag: imem_rvalid arrived with nothing outstanding

Behaviour:
- Reset (synchronous, wins over everything):
  - fetch_pc=RESET_PC; queue count=0; outstanding=0; discard=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, protocol_error=0, decoded fields=0.
  - A reset asserted mid-fetch abandons the fetch. A later stale imem_rvalid then sets protocol_error.
- State per cycle:
  - fetch_pc, outstanding (0/1), discard (0/1).
  - Queue of 2 entries {pc, word} with head/tail pointers that wrap modulo 2.
- Request issue:
  - imem_req=1 in cycle c+1 iff, at the end of cycle c, outstanding=0, discard=0 and post-update count<2.
  - When it issues: imem_addr=fetch_pc, outstanding<=1, fetch_pc<=fetch_pc+4 (modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0).
  - At most one request is outstanding.
- Response:
  - imem_rvalid with outstanding=1 and discard=0: push {issued addr, imem_rdata}; outstanding<=0.
  - Memory latency L≥1 cycles.
  - Entry is visible on instr_valid in the cycle after imem_rvalid.
  - Next request goes out in that same cycle if space allows.
  - With L=1, steady throughput is 1 instruction per 2 cycles.
- Dequeue:
  - Handshake is instr_valid && instr_ready.
  - Head pops at the clock edge; the next entry appears the following cycle.
  - Push and pop in the same cycle: count is unchanged.
  - Push never occurs with count=2, because issue requires space.
- Outputs:
  - instr_valid = (count≠0).
  - instr/instr_pc come from the head; decoded fields are bit-slices of instr.
  - All are 0 when empty.
  - They hold stable while instr_valid=1 and instr_ready=0.
- Redirect (redirect_valid=1 in cycle c):
  - Queue flushed (count<=0); instr_valid=0 from c+1.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}; low bits are masked.
  - If a fetch is outstanding and its rvalid is not in cycle c, set discard<=1.
  - Redirect has priority over a simultaneous rvalid push and a simultaneous pop. The rvalid-cycle word is dropped and outstanding cleared.
- Discard:
  - The next imem_rvalid is dropped; discard<=0 and outstanding<=0.
  - A new request (to the redirect target) issues in the following cycle.
- A second redirect while discard=1 only updates fetch_pc; discard stays 1.
- imem_rvalid with outstanding=0: ignored, and protocol_error<=1 (cleared only by reset).

Test Plan:
- Reset release with RESET_PC=0, memory L=1, instr_ready=1 -> imem_req pulses at addr 0,4,8 on alternate cycles. instr_valid shows instr_pc 0,4,8 in order with matching instr. For word 32'h40B50533, decode gives opcode=7'h33, funct3=0, funct7=7'h20, rd=10, rs1=10, rs2=11.
- instr_ready=0, L=1 -> exactly 2 requests (addr 0,4), then imem_req stays 0. instr holds PC 0's word stable. Raise instr_ready -> pops in order; fetch resumes at addr 8.
- Request at addr 8 outstanding with L=4; redirect to 32'h0000_0102 on the 2nd wait cycle -> queue flushed next cycle. Stale rvalid is dropped (no instr_valid). imem_req to 32'h0000_0100 on the cycle after the stale rvalid.
- Redirect in the same cycle as rvalid and instr_ready=1 with count=1 -> no push. instr_valid=0 next cycle. Next request goes to the redirect target with no discard wait.
- Redirect to 32'hFFFF_FFFC with L=1 -> fetches 32'hFFFF_FFFC, then 32'h0000_0000. instr_pc order matches.
- imem_rvalid pulsed 3 cycles after reset with no request -> protocol_error=1 and it stays 1. No queue entry is created. Reset clears it to 0.
